// File: rtl/arith_operand_sequencer_pkg.sv
// Shared constants for the operand sequencer: default widths, state encoding,
// operand slot indices and the quotient substituted on divide-by-zero.
package arith_operand_sequencer_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_RW = DEF_W + 1;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_EXEC    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam logic [DEF_RW-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/arith_operand_sequencer.sv
// Collects a,b,c,d serially, presents them stable to the operator block for one
// cycle, then captures and holds the results behind a valid/ready handshake.
module arith_operand_sequencer
  import arith_operand_sequencer_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic [W-1:0]  op_c,
  output logic [W-1:0]  op_d,
  input  logic [RW-1:0] res_x,
  input  logic [RW-1:0] res_y,
  input  logic [RW-1:0] res_z,
  input  logic [RW-1:0] res_u,
  input  logic [RW-1:0] res_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_x,
  output logic [RW-1:0] out_y,
  output logic [RW-1:0] out_z,
  output logic [RW-1:0] out_u,
  output logic [RW-1:0] out_v,
  output logic          div_zero,
  output logic          mul_ovf
);

  localparam logic [2*W-1:0] RES_MAX = (2*W)'((1 << RW) - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d, op_d_q, op_d_d;
  logic [RW-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic [RW-1:0] out_u_q, out_u_d, out_v_q, out_v_d;
  logic          out_valid_q, out_valid_d;
  logic          div_zero_q, div_zero_d;
  logic          mul_ovf_q, mul_ovf_d;
  logic          accept;
  logic [2*W-1:0] prod;

  // Full-width product so overflow is judged on the true value, not res_u.
  assign prod   = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};
  assign accept = in_valid && (state_q == ST_COLLECT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    op_d_d      = op_d_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    out_u_d     = out_u_q;
    out_v_d     = out_v_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    mul_ovf_d   = mul_ovf_q;

    if (flush) begin
      // Abort drops any same-cycle handshake; captured results stay visible.
      state_d     = ST_COLLECT;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      op_a_d      = '0;
      op_b_d      = '0;
      op_c_d      = '0;
      op_d_d      = '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            case (cnt_q)
              SLOT_A:  op_a_d = in_data;
              SLOT_B:  op_b_d = in_data;
              SLOT_C:  op_c_d = in_data;
              default: op_d_d = in_data;
            endcase
            if (cnt_q == SLOT_D) begin
              state_d = ST_EXEC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        ST_EXEC: begin
          out_x_d     = res_x;
          out_y_d     = res_y;
          out_u_d     = res_u;
          mul_ovf_d   = (prod > RES_MAX);
          if (op_c_q == '0) begin
            out_z_d    = DIV0_QUOT;
            out_v_d    = {{(RW-W){1'b0}}, op_d_q};
            div_zero_d = 1'b1;
          end else begin
            out_z_d    = res_z;
            out_v_d    = res_v;
            div_zero_d = 1'b0;
          end
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_COLLECT;
          end
        end
        default: begin
          state_d     = ST_COLLECT;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      op_d_q      <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_u_q     <= '0;
      out_v_q     <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      mul_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      op_d_q      <= op_d_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      out_u_q     <= out_u_d;
      out_v_q     <= out_v_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      mul_ovf_q   <= mul_ovf_d;
    end
  end

  // in_ready is gated by rst directly so it falls the instant reset asserts.
  assign in_ready  = (state_q == ST_COLLECT) && !rst;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_c      = op_c_q;
  assign op_d      = op_d_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_u     = out_u_q;
  assign out_v     = out_v_q;
  assign div_zero  = div_zero_q;
  assign mul_ovf   = mul_ovf_q;

endmodule

// File: doc/arith_operand_sequencer.md
Name: arith_operand_sequencer

Overview:
- Upstream feeder and downstream result stage for the team's combinational arithmetic operator block. That block takes operands a, b, c, d (4 bits each) and returns x=a+b, y=b-a, z=d/c, u=a*b, v=d%c (5 bits each).
- This block collects the four operands serially from a narrow valid/ready stream and presents them stable to the operator block. It then registers the five results and holds them behind a valid/ready output handshake.
- It adds divide-by-zero and multiply-overflow flags, and substitutes defined results when c is zero.

Parameters:
- W, 4, operand width. Must match the operator block's operand width.
- RW, 5, result width. Equals W+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort; discards the partial operand set and any held result
- in_valid  input  1  operand word valid
- in_ready  output  1  block accepts an operand word
- in_data  input  W  operand word; order is a, b, c, d
- op_a, op_b, op_c, op_d  output  W each  registered operands to the operator block
- res_x, res_y, res_z, res_u, res_v  input  RW each  results from the operator block
- out_valid  output  1  result set valid
- out_ready  input  1  consumer accepts the result set
- out_x, out_y, out_z, out_u, out_v  output  RW each  registered results
- div_zero  output  1  operand c was 0 for this result set
- mul_ovf  output  1  true product a*b exceeded 2^RW-1

Behaviour:
- Reset (asynchronous, rst=1) clears the following, effective immediately and in any state, including mid-collect and mid-hold:
  - state to COLLECT, cnt to 0
  - in_ready=0 while rst is asserted, 1 after release
  - op_* = 0, out_* = 0, out_valid=0, div_zero=0, mul_ovf=0
- States: COLLECT, EXEC, HOLD.
- COLLECT:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data into slot cnt (0=a, 1=b, 2=c, 3=d), then cnt increments.
  - The handshake at cnt=3 moves the state to EXEC and resets cnt to 0.
  - in_valid low: no change.
- EXEC (exactly 1 cycle):
  - in_ready=0; op_* are stable.
  - At the end of the cycle, res_* are captured into out_*. Then out_valid=1 and the state moves to HOLD.
- Divide by zero: if op_c==0, the capture ignores res_z and res_v and writes:
  - out_z = all ones (5'h1F)
  - out_v = op_d zero-extended
  - div_zero = 1
- mul_ovf: computed in this block from the full 2W-bit product op_a*op_b. It is 1 if the product exceeds 2^RW-1.
- Width rules:
  - out_u = res_u, which is the product truncated mod 2^RW.
  - out_y = res_y, which is b-a wrapped mod 2^RW.
  - No saturation is applied.
- HOLD:
  - in_ready=0.
  - out_* and the flags are held stable while out_ready=0, with no limit.
  - On out_valid & out_ready: out_valid drops to 0 and the state moves to COLLECT.
  - out_* and the flags keep their last values until the next capture.
- Latency: the 4th operand is accepted in cycle N; out_valid=1 in cycle N+2.
- Minimum period: 6 cycles per result set (4 accepts, EXEC, HOLD with out_ready=1).
- flush (synchronous), in any state:
  - next state COLLECT, cnt=0, out_valid=0
  - op_* cleared; out_* retained
  - any in_valid handshake in the same cycle is dropped
- flush has priority over every other event; rst has priority over flush.
- op_* change only on an accepted operand write, flush, or reset. They never change during EXEC.

Decomposition:
- Shared package: W/RW defaults, the state encoding (COLLECT, EXEC, HOLD), operand slot indices (SLOT_A to SLOT_D), and the DIV0_QUOT constant (all ones).
- No sub-module inside this block. The operator block is instantiated alongside it at the next level up.
- A wrapper pairing the two is natural: arith_unit_top.

Test Plan:
- Basic set: stream 5, 3, 2, 9 back-to-back → out_valid 2 cycles after the 4th accept, with x=8, y=30, z=4, u=15, v=1, div_zero=0, mul_ovf=0.
- Overflow: stream 15, 15, 1, 7 → u=1 (225 mod 32), mul_ovf=1, x=30, y=0, z=7, v=0.
- Divide by zero: stream 2, 4, 0, 9 → z=31, v=9, div_zero=1, x=6, y=2, u=8.
- Backpressure and gaps:
  - Toggle in_valid randomly; only handshake cycles advance cnt.
  - Hold out_ready=0 for 5 cycles; outputs stay stable and in_ready stays 0.
  - Then assert out_ready=1; the next set is accepted starting the following cycle.
- Abort:
  - flush after 2 operands → cnt restarts. The next 4 words form a full set, and the pre-flush words are not used.
  - Assert rst asynchronously mid-HOLD → out_valid drops at once and all outputs read 0.
